// File: rtl/pc_net_pkg.sv
// Shared definitions for the PC/hub serial network: frame geometry, broadcast
// address and the bit-level receiver state encoding.
package pc_net_pkg;

    localparam int MAC_BYTES     = 6;
    localparam int PAYLOAD_BYTES = 70;
    localparam int FRAME_BYTES   = 2 * MAC_BYTES + PAYLOAD_BYTES;

    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } bit_state_t;

    // Byte idx of a MAC in wire order (byte 0 is the most significant).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int idx);
        logic [47:0] t;
        t = mac >> (8 * (MAC_BYTES - 1 - idx));
        return t[7:0];
    endfunction

endpackage

// File: rtl/serial_byte_rx.sv
// Serial byte receiver: 2-flop synchronizer, start/data/stop bit FSM and
// LSB-first shifter. Emits one byte_done or frame_bit_err pulse per character.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_bit_err,
    output logic       line_idle
);
    import pc_net_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    bit_state_t      state;
    logic            rx_meta;
    logic            rxs;
    logic            rxs_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    assign line_idle = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rxs           <= 1'b1;
            rxs_d         <= 1'b1;
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_byte       <= '0;
            byte_done     <= 1'b0;
            frame_bit_err <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rxs           <= rx_meta;
            rxs_d         <= rxs;
            byte_done     <= 1'b0;
            frame_bit_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rxs_d && !rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                // Re-check the start bit at mid-bit to reject line glitches.
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_byte   <= shreg;
                            byte_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            frame_bit_err <= 1'b1;
                            state         <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pc_frame_rx.sv
// PC receive frame engine: counts bytes into frames, filters on destination
// MAC (own or broadcast), captures source MAC and streams accepted payload.
module pc_frame_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FRAME_BYTES  = 82,
    parameter int GAP_BITS     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] mac_address,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [47:0] src_mac,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_drop,
    output logic        frame_err
);
    import pc_net_pkg::*;

    localparam int BW = $clog2(FRAME_BYTES);
    localparam logic [BW-1:0] LAST_DST  = BW'(MAC_BYTES - 1);
    localparam logic [BW-1:0] LAST_SRC  = BW'(2 * MAC_BYTES - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [7:0]    rx_byte;
    logic          byte_done;
    logic          frame_bit_err;
    logic          line_idle;
    logic [BW-1:0] byte_cnt;
    logic          match;
    logic          bcast;
    logic          match_n;
    logic          bcast_n;
    logic          accept;
    logic [47:0]   src_shadow;
    logic [GW-1:0] gap_cnt;

    serial_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .byte_done     (byte_done),
        .frame_bit_err (frame_bit_err),
        .line_idle     (line_idle)
    );

    // Both flags start at 1 each frame and can only fall during bytes 0-5.
    always_comb begin
        match_n = match & (rx_byte == mac_byte(mac_address, int'(byte_cnt)));
        bcast_n = bcast & (rx_byte == mac_byte(BROADCAST_MAC, int'(byte_cnt)));
    end

    assign accept = match | bcast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= '0;
            match       <= 1'b1;
            bcast       <= 1'b1;
            src_shadow  <= '0;
            src_mac     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_drop  <= 1'b0;
            frame_err   <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_drop  <= 1'b0;
            frame_err   <= 1'b0;
            if (frame_bit_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
                match     <= 1'b1;
                bcast     <= 1'b1;
                gap_cnt   <= '0;
            end else if (byte_done) begin
                gap_cnt <= '0;
                if (byte_cnt == '0) frame_start <= 1'b1;
                if (byte_cnt <= LAST_DST) begin
                    match <= match_n;
                    bcast <= bcast_n;
                end else if (byte_cnt <= LAST_SRC) begin
                    src_shadow <= {src_shadow[39:0], rx_byte};
                    if (byte_cnt == LAST_SRC && accept) src_mac <= {src_shadow[39:0], rx_byte};
                end else if (accept) begin
                    data_out   <= rx_byte;
                    data_valid <= 1'b1;
                end
                if (byte_cnt == LAST_BYTE) begin
                    frame_done <= accept;
                    frame_drop <= !accept;
                    byte_cnt   <= '0;
                    match      <= 1'b1;
                    bcast      <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_cnt != '0 && line_idle) begin
                // A silent line inside a frame means the sender went away.
                if (gap_cnt == GAP_LAST) begin
                    frame_err <= 1'b1;
                    byte_cnt  <= '0;
                    match     <= 1'b1;
                    bcast     <= 1'b1;
                    gap_cnt   <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pc_frame_rx.sv
// Directed bench for pc_frame_rx: unicast, drop, broadcast, framing error,
// gap timeout, glitch rejection and mid-frame reset.
module tb_pc_frame_rx;
    localparam int CPB = 4;
    localparam logic [47:0] MAC = 48'h000A959D6816;
    localparam logic [47:0] SRC = 48'h000B846D6817;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [47:0] src_mac;
    logic        frame_start, frame_done, frame_drop, frame_err;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_start = 0, n_done = 0, n_drop = 0, n_err = 0, n_done_vld = 0;
    int s_valid, s_start, s_done, s_drop, s_err, s_done_vld;
    logic [7:0] rcv[$];

    pc_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(82), .GAP_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mac_address (MAC),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .src_mac     (src_mac),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_drop  (frame_drop),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            rcv.push_back(data_out);
            n_valid++;
        end
        if (frame_start) n_start++;
        if (frame_done) n_done++;
        if (frame_drop) n_drop++;
        if (frame_err) n_err++;
        if (frame_done && data_valid) n_done_vld++;
    end

    task automatic snap();
        s_valid = n_valid; s_start = n_start; s_done = n_done;
        s_drop = n_drop; s_err = n_err; s_done_vld = n_done_vld;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int j = 0; j < 8; j++) bit_time(b[j]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                              input logic [7:0] pb, input int nbytes, input int bad_idx);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 6) b = dest[47-8*i -: 8];
            else if (i < 12) b = src[47-8*(i-6) -: 8];
            else b = pb + 8'(i - 12);
            send_byte(b, i != bad_idx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", data_valid); end
        checks++; if (src_mac !== 48'h0) begin errors++; $display("FAIL rst_src got %h want 0", src_mac); end
        checks++; if ({frame_start, frame_done, frame_drop, frame_err} !== 4'b0000) begin
            errors++; $display("FAIL rst_pulses got %b want 0000", {frame_start, frame_done, frame_drop, frame_err}); end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_unicast();
        snap();
        send_frame(MAC, SRC, 8'h00, 82, -1);
        idle(20);
        checks++; if (n_valid - s_valid !== 70) begin errors++; $display("FAIL uni_count got %0d want 70", n_valid - s_valid); end
        for (int i = 0; i < 70 && s_valid + i < rcv.size(); i++) begin
            checks++; if (rcv[s_valid+i] !== 8'(i)) begin errors++; $display("FAIL uni_data[%0d] got %h want %h", i, rcv[s_valid+i], 8'(i)); end
        end
        checks++; if (n_start - s_start !== 1) begin errors++; $display("FAIL uni_start got %0d want 1", n_start - s_start); end
        checks++; if (n_done - s_done !== 1) begin errors++; $display("FAIL uni_done got %0d want 1", n_done - s_done); end
        checks++; if (n_done_vld - s_done_vld !== 1) begin errors++; $display("FAIL uni_done_with_valid got %0d want 1", n_done_vld - s_done_vld); end
        checks++; if (n_drop - s_drop + n_err - s_err !== 0) begin errors++; $display("FAIL uni_drop_err got %0d want 0", n_drop - s_drop + n_err - s_err); end
        checks++; if (src_mac !== SRC) begin errors++; $display("FAIL uni_src got %h want %h", src_mac, SRC); end
    endtask

    task automatic test_drop();
        snap();
        send_frame(48'h00A6646D9C97, 48'h112233445566, 8'h80, 82, -1);
        idle(20);
        checks++; if (n_valid - s_valid !== 0) begin errors++; $display("FAIL drop_count got %0d want 0", n_valid - s_valid); end
        checks++; if (n_drop - s_drop !== 1) begin errors++; $display("FAIL drop_pulse got %0d want 1", n_drop - s_drop); end
        checks++; if (n_done - s_done !== 0) begin errors++; $display("FAIL drop_done got %0d want 0", n_done - s_done); end
        checks++; if (n_start - s_start !== 1) begin errors++; $display("FAIL drop_start got %0d want 1", n_start - s_start); end
        checks++; if (src_mac !== SRC) begin errors++; $display("FAIL drop_src got %h want %h", src_mac, SRC); end
    endtask

    task automatic test_broadcast();
        snap();
        send_frame(48'hFFFF_FFFF_FFFF, 48'h010203040506, 8'h10, 82, -1);
        idle(20);
        checks++; if (n_valid - s_valid !== 70) begin errors++; $display("FAIL bc_count got %0d want 70", n_valid - s_valid); end
        for (int i = 0; i < 70 && s_valid + i < rcv.size(); i++) begin
            checks++; if (rcv[s_valid+i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL bc_data[%0d] got %h want %h", i, rcv[s_valid+i], 8'(8'h10 + i)); end
        end
        checks++; if (n_done - s_done !== 1) begin errors++; $display("FAIL bc_done got %0d want 1", n_done - s_done); end
        checks++; if (n_drop - s_drop !== 0) begin errors++; $display("FAIL bc_drop got %0d want 0", n_drop - s_drop); end
        checks++; if (src_mac !== 48'h010203040506) begin errors++; $display("FAIL bc_src got %h want 010203040506", src_mac); end
    endtask

    task automatic test_framing_err();
        snap();
        send_frame(MAC, SRC, 8'h20, 31, 30);
        idle(120);
        checks++; if (n_valid - s_valid !== 18) begin errors++; $display("FAIL ferr_count got %0d want 18", n_valid - s_valid); end
        if (rcv.size() > 0) begin
            checks++; if (rcv[rcv.size()-1] !== 8'h31) begin errors++; $display("FAIL ferr_last got %h want 31", rcv[rcv.size()-1]); end
        end
        checks++; if (n_err - s_err !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", n_err - s_err); end
        checks++; if (n_done - s_done !== 0) begin errors++; $display("FAIL ferr_done got %0d want 0", n_done - s_done); end
        snap();
        send_frame(MAC, SRC, 8'h40, 82, -1);
        idle(20);
        checks++; if (n_valid - s_valid !== 70) begin errors++; $display("FAIL recov_count got %0d want 70", n_valid - s_valid); end
        for (int i = 0; i < 70 && s_valid + i < rcv.size(); i++) begin
            checks++; if (rcv[s_valid+i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL recov_data[%0d] got %h want %h", i, rcv[s_valid+i], 8'(8'h40 + i)); end
        end
        checks++; if (n_done - s_done !== 1 || n_err - s_err !== 0) begin
            errors++; $display("FAIL recov_done_err got %0d/%0d want 1/0", n_done - s_done, n_err - s_err); end
    endtask

    task automatic test_gap();
        int at;
        at = -1;
        snap();
        send_frame(MAC, SRC, 8'h00, 21, -1);
        rx = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (frame_err && at < 0) at = k;
        end
        checks++; if (at < 60 || at > 72) begin errors++; $display("FAIL gap_timeout got cycle %0d want 60..72", at); end
        checks++; if (n_err - s_err !== 1) begin errors++; $display("FAIL gap_err_count got %0d want 1", n_err - s_err); end
        checks++; if (n_valid - s_valid !== 9) begin errors++; $display("FAIL gap_valid got %0d want 9", n_valid - s_valid); end
        snap();
        rx = 1'b0;
        @(negedge clk);
        idle(60);
        checks++; if (n_valid - s_valid + n_start - s_start + n_err - s_err !== 0) begin
            errors++; $display("FAIL glitch_events got %0d want 0", n_valid - s_valid + n_start - s_start + n_err - s_err); end
    endtask

    task automatic test_reset_mid();
        send_frame(MAC, 48'h0A0B0C0D0E0F, 8'h50, 50, -1);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mrst_data got %h want 00", data_out); end
        checks++; if (src_mac !== 48'h0) begin errors++; $display("FAIL mrst_src got %h want 0", src_mac); end
        checks++; if ({data_valid, frame_start, frame_done, frame_drop, frame_err} !== 5'b00000) begin
            errors++; $display("FAIL mrst_pulses got %b want 00000", {data_valid, frame_start, frame_done, frame_drop, frame_err}); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(10);
        snap();
        send_frame(MAC, 48'h0A0B0C0D0E0F, 8'h60, 82, -1);
        idle(20);
        checks++; if (n_valid - s_valid !== 70) begin errors++; $display("FAIL post_count got %0d want 70", n_valid - s_valid); end
        for (int i = 0; i < 70 && s_valid + i < rcv.size(); i++) begin
            checks++; if (rcv[s_valid+i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL post_data[%0d] got %h want %h", i, rcv[s_valid+i], 8'(8'h60 + i)); end
        end
        checks++; if (n_start - s_start !== 1 || n_done - s_done !== 1 || n_err - s_err !== 0) begin
            errors++; $display("FAIL post_pulses got %0d/%0d/%0d want 1/1/0", n_start - s_start, n_done - s_done, n_err - s_err); end
        checks++; if (src_mac !== 48'h0A0B0C0D0E0F) begin errors++; $display("FAIL post_src got %h want 0a0b0c0d0e0f", src_mac); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unicast();
        test_drop();
        test_broadcast();
        test_framing_err();
        test_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_frame_rx.md
# pc_frame_rx

Receive-side frame engine for a PC endpoint on the hub network. It deserializes the PC's `rx` line, which is driven by a hub `tx` port, into bytes and assembles 82-byte frames: 6-byte destination MAC, 6-byte source MAC, then 70 payload bytes. It filters each frame on destination address and delivers payload bytes of accepted frames to the PC core. It complements the PC transmit path, which serializes frames onto `tx`.

## Interface
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥4 and even.
- `FRAME_BYTES`, 82: total bytes per frame (6+6+70).
- `GAP_BITS`, 16: idle bit-times inside a frame that abort it.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mac_address`  in  48  own MAC; byte 0 of the wire is `[47:40]`.
- `rx`  in  1  serial line from hub; idles high.
- `data_out`  out  8  payload byte.
- `data_valid`  out  1  one-cycle strobe; `data_out` valid. There is no backpressure.
- `src_mac`  out  48  source MAC of the last accepted frame.
- `frame_start`  out  1  pulse when byte 0 completes.
- `frame_done`  out  1  pulse after the last payload byte of an accepted frame.
- `frame_drop`  out  1  pulse at the end of a frame whose destination did not match.
- `frame_err`  out  1  pulse on a framing error or gap timeout.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below sees the synchronized `rxs`.
- Byte format: start bit (0), then 8 data bits LSB first, then a stop bit (1).
- Bit FSM states:
  - IDLE → START on a falling edge of `rxs`.
  - START waits `CLKS_PER_BIT/2` cycles, then samples. If the sample is 1 it is a false start → IDLE. If 0 → DATA.
  - DATA takes 8 samples, one every `CLKS_PER_BIT` cycles, shifting right.
  - STOP samples after `CLKS_PER_BIT` more cycles. A sample of 1 gives byte done → IDLE. A sample of 0 is a framing error → WAIT_HIGH.
  - WAIT_HIGH → IDLE once `rxs`=1.
- Frame counter `byte_cnt` runs 0..`FRAME_BYTES`-1 and increments on each byte done.
  - Bytes 0–5: compared against the matching `mac_address` byte. A match flag clears on the first mismatch. If all six bytes equal 0xFF, the frame is a broadcast and is accepted.
  - Bytes 6–11: shifted into a src shadow register. `src_mac` updates from the shadow at byte 11 only if the frame is accepted.
  - Bytes 12–81: if accepted, each byte produces `data_out`/`data_valid`. If rejected, bytes are consumed silently.
  - Byte 81 done: pulse `frame_done` (accepted) or `frame_drop` (rejected), then `byte_cnt` returns to 0.
- Framing error mid-frame: pulse `frame_err`, set `byte_cnt`=0, and the match flag returns to 1. The partial frame's remaining payload is never delivered.
- Gap timeout: `byte_cnt`≠0 and the bit FSM stays in IDLE for `GAP_BITS*CLKS_PER_BIT` cycles → `frame_err` pulse, `byte_cnt`=0.
- Asserting `reset` mid-frame discards all state immediately. The first frame after reset must begin with a fresh start bit.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `src_mac`=0, all pulse outputs 0, FSM in IDLE, `byte_cnt`=0.
- Latency: `data_valid` rises exactly 1 cycle after the STOP sample cycle. The STOP sample occurs `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the `rxs` falling edge. Add 2 cycles from raw `rx` for the synchronizer.
- Each pulse output is high for exactly 1 cycle.
- `frame_done` is coincident with the `data_valid` of byte 81.
- `frame_start` is coincident with the byte-0 done cycle.
- A start bit may begin immediately after the stop sample, which allows back-to-back bytes with a zero-length idle.
- The gap counter clears on any byte done and on any falling edge of `rxs`.

## Structure
- Shared package `pc_net_pkg` holds:
  - `MAC_BYTES`=6, `PAYLOAD_BYTES`=70, and `FRAME_BYTES` derived from them.
  - `BROADCAST_MAC`=48'hFFFF_FFFF_FFFF.
  - The bit-FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH). The PC transmitter and the hub reuse these.
- One sub-module: `serial_byte_rx`, containing the synchronizer, bit FSM and shifter. It outputs `byte`, `byte_done`, `frame_bit_err` and `line_idle`. `pc_frame_rx` implements the frame counter, filtering and timeout.

## Test plan
- Bench parameters: `CLKS_PER_BIT`=4, `mac_address`=48'h000A959D6816.
- Send dest 00 0A 95 9D 68 16, src 00 0B 84 6D 68 17, payload 0x00..0x45 → 70 `data_valid` strobes with values 0x00..0x45 in order, one `frame_start`, one `frame_done`, and `src_mac`=48'h000B846D6817.
- Send a frame with dest 00 A6 64 6D 9C 97 → no `data_valid`, one `frame_drop`, `src_mac` unchanged.
- Send a frame with dest FF FF FF FF FF FF → accepted with 70 strobes and `frame_done`.
- Drive a stop bit of 0 on byte 30 → one `frame_err`, no further strobes. A following valid frame is accepted normally.
- Stop after byte 20 and hold the line idle for 64 cycles → `frame_err` at cycle 64 of the idle period. Inject a 1-cycle low glitch → false start with no byte.
- Assert `reset` during byte 50 → all outputs 0 on the next edge. A subsequent full frame is delivered intact.
